// File: rtl/wbcon_exec.sv
// wbcon_exec: executes parsed wbcon commands as Wishbone classic word reads/writes.
// Define WBCON_EXEC_TIMEOUT_EN to add an 8-bit bus-beat watchdog.
module wbcon_exec #(
  parameter int ADDR_WIDTH  = 12,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_mreq_valid,
  output logic                   o_mreq_ready,
  input  logic [ADDR_WIDTH-1:0]  i_mreq_addr,
  input  logic [COUNT_WIDTH-1:0] i_mreq_cnt,
  input  logic                   i_mreq_wr,
  input  logic                   i_mreq_aincr,
  input  logic [7:0]             i_body_data,
  input  logic                   i_body_valid,
  output logic                   o_body_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_wb_cyc,
  output logic                   o_wb_stb,
  output logic                   o_wb_we,
  output logic [ADDR_WIDTH-1:0]  o_wb_adr,
  output logic [31:0]            o_wb_dat,
  output logic [3:0]             o_wb_sel,
  input  logic [31:0]            i_wb_dat,
  input  logic                   i_wb_ack,
  input  logic                   i_wb_err,
  output logic                   o_err
);
  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_BUS, RD_BUS, RD_SEND, NEXT} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [COUNT_WIDTH-1:0] beats;
  logic                   wr, aincr, err_q, bus, to, done, berr;
  logic [1:0]             bcnt;
  logic [31:0]            wdata, rdata;
  assign bus = state == WR_BUS || state == RD_BUS;
`ifdef WBCON_EXEC_TIMEOUT_EN
  logic [7:0] wd;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) wd <= 8'd0;
    else wd <= bus ? wd + 8'd1 : 8'd0;
  assign to = bus && wd == 8'd255;
`else
  assign to = 1'b0;
`endif
  assign done = i_wb_ack | i_wb_err | to;
  // a late ack still wins over the watchdog; a real err always wins over ack
  assign berr = i_wb_err | (to & ~i_wb_ack);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (i_mreq_valid) state_nx = i_mreq_wr ? WR_COLLECT : RD_BUS;
      WR_COLLECT: if (i_body_valid && bcnt == 2'd3) state_nx = WR_BUS;
      WR_BUS:     if (done) state_nx = NEXT;
      RD_BUS:     if (done) state_nx = RD_SEND;
      RD_SEND:    if (i_tx_ready && bcnt == 2'd3) state_nx = NEXT;
      NEXT:       state_nx = beats == '0 ? IDLE : wr ? WR_COLLECT : RD_BUS;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      addr  <= '0;
      beats <= '0;
      wr    <= 1'b0;
      aincr <= 1'b0;
      bcnt  <= 2'd0;
      wdata <= 32'd0;
      rdata <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= bus && berr;
      if (state == IDLE && i_mreq_valid) begin
        addr  <= i_mreq_addr;
        beats <= i_mreq_cnt;
        wr    <= i_mreq_wr;
        aincr <= i_mreq_aincr;
        bcnt  <= 2'd0;
      end
      if (state == WR_COLLECT && i_body_valid) begin
        wdata <= {i_body_data, wdata[31:8]};
        bcnt  <= bcnt + 2'd1;
      end
      if (state == RD_BUS && done) rdata <= berr ? 32'd0 : i_wb_dat;
      if (state == RD_SEND && i_tx_ready) bcnt <= bcnt + 2'd1;
      if (state == NEXT && beats != '0) begin
        beats <= beats - COUNT_WIDTH'(1);
        if (aincr) addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end
  assign o_mreq_ready = state == IDLE && i_rst_n;
  assign o_body_ready = state == WR_COLLECT;
  assign o_tx_valid   = state == RD_SEND;
  assign o_tx_data    = 8'(rdata >> {bcnt, 3'b000});
  assign o_wb_cyc     = bus;
  assign o_wb_stb     = bus;
  assign o_wb_we      = state == WR_BUS;
  assign o_wb_adr     = addr;
  assign o_wb_dat     = wdata;
  assign o_wb_sel     = {4{bus}};
  assign o_err        = err_q;
endmodule

// File: tb/tb_wbcon_exec.sv
// tb_wbcon_exec: random and directed commands against a word-level command model and a memory slave.
module tb_wbcon_exec;
  localparam int AW = 12, CW = 10;
  logic i_clk = 0, i_rst_n = 0;
  logic i_mreq_valid = 0, o_mreq_ready;
  logic [AW-1:0] i_mreq_addr = 0;
  logic [CW-1:0] i_mreq_cnt = 0;
  logic i_mreq_wr = 0, i_mreq_aincr = 0;
  logic [7:0] i_body_data = 0;
  logic i_body_valid = 0, o_body_ready;
  logic [7:0] o_tx_data;
  logic o_tx_valid, i_tx_ready = 0;
  logic o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_adr;
  logic [31:0] o_wb_dat, i_wb_dat = 0;
  logic [3:0] o_wb_sel;
  logic i_wb_ack = 0, i_wb_err = 0, o_err;

  wbcon_exec #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_mreq_valid(i_mreq_valid), .o_mreq_ready(o_mreq_ready), .i_mreq_addr(i_mreq_addr),
    .i_mreq_cnt(i_mreq_cnt), .i_mreq_wr(i_mreq_wr), .i_mreq_aincr(i_mreq_aincr),
    .i_body_data(i_body_data), .i_body_valid(i_body_valid), .o_body_ready(o_body_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .i_wb_dat(i_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {logic [AW-1:0] adr; logic we; logic [31:0] dat; logic [3:0] sel;} beat_t;
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  bit slave_en = 1;
  int err_plan[$];
  beat_t obs[$];
  int dly = 0;

  // err_plan per beat: 0 ack, 1 err, 2 ack and err together
  initial forever begin
    int e;
    @(negedge i_clk);
    i_wb_ack = 0;
    i_wb_err = 0;
    if (slave_en && o_wb_cyc && o_wb_stb) begin
      if (dly > 0) dly--;
      else begin
        e = err_plan.size() != 0 ? err_plan.pop_front() : 0;
        obs.push_back('{o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel});
        if (e == 0) begin
          i_wb_ack = 1;
          if (o_wb_we) mem[o_wb_adr] = o_wb_dat;
          else i_wb_dat = mem[o_wb_adr];
        end else begin
          i_wb_err = 1;
          i_wb_ack = (e == 2);
          i_wb_dat = $urandom;
        end
        dly = $urandom_range(0, 2);
      end
    end
  end

  logic [7:0] body_q[$];
  int plan_q[$];

  task automatic run_cmd(input logic [AW-1:0] a, input int cnt, input bit wr, input bit aincr, input bit rnd);
    logic [AW-1:0] ea[$];
    logic [31:0] ed[$];
    logic [7:0] exp_tx[$], txq[$], hold_byte;
    int nerr = 0, perr = 0, bi = 0, cyc = 0;
    bit held = 0;
    logic [AW-1:0] x;
    logic [31:0] w;
    for (int k = 0; k <= cnt; k++) begin
      x = aincr ? AW'(a + k) : a;
      ea.push_back(x);
      if (plan_q[k] != 0) perr++;
      if (wr) begin
        w = {body_q[4*k+3], body_q[4*k+2], body_q[4*k+1], body_q[4*k]};
        ed.push_back(w);
        if (plan_q[k] == 0) ref_mem[x] = w;
      end else begin
        w = plan_q[k] != 0 ? 32'd0 : ref_mem[x];
        for (int b = 0; b < 4; b++) exp_tx.push_back(8'(w >> (8*b)));
      end
    end
    err_plan = plan_q;
    obs.delete();
    @(negedge i_clk);
    check("mreq_ready_idle", o_mreq_ready, 1);
    i_mreq_valid = 1; i_mreq_addr = a; i_mreq_cnt = CW'(cnt); i_mreq_wr = wr; i_mreq_aincr = aincr;
    while (cyc < 5000) begin
      @(negedge i_clk);
      cyc++;
      i_mreq_valid = 0;
      if (o_err) nerr++;
      if (held) check("tx_hold", o_tx_data, hold_byte);
      i_body_valid = bi < body_q.size() && (!rnd || $urandom_range(0, 3) != 0);
      i_body_data = bi < body_q.size() ? body_q[bi] : 8'h00;
      if (o_body_ready && i_body_valid) bi++;
      i_tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'(cyc % 2 == 0);
      held = o_tx_valid && !i_tx_ready;
      hold_byte = o_tx_data;
      if (o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
      if (o_mreq_ready) break;
    end
    i_body_valid = 0;
    i_tx_ready = 0;
    check("cmd_done", o_mreq_ready, 1);
    check("nbeats", obs.size(), cnt + 1);
    for (int k = 0; k <= cnt && k < obs.size(); k++) begin
      check("beat_adr", obs[k].adr, ea[k]);
      check("beat_we", obs[k].we, wr);
      check("beat_sel", obs[k].sel, 4'hF);
      if (wr) check("beat_dat", obs[k].dat, ed[k]);
    end
    check("ntx", txq.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++) check("tx_byte", txq[i], exp_tx[i]);
    check("err_pulses", nerr, perr);
    body_q.delete();
    plan_q.delete();
  endtask

  task automatic fill(input int cnt, input bit wr, input bit rnd_err);
    for (int k = 0; k <= cnt; k++) begin
      int r = $urandom_range(0, 9);
      plan_q.push_back(rnd_err ? (r == 0 ? 1 : r == 1 ? 2 : 0) : 0);
      if (wr) for (int b = 0; b < 4; b++) body_q.push_back(8'($urandom));
    end
  endtask

  initial begin
    int n;
    logic [31:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    #23;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_mreq_ready", o_mreq_ready, 0);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_body_ready", o_body_ready, 0);
    check("rst_err", o_err, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    check("post_rst_ready", o_mreq_ready, 1);

    body_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    plan_q = '{0, 0};
    run_cmd(12'hCDD, 1, 1, 1, 0);
    check("wr_mem0", mem[12'hCDD], 32'h44332211);
    check("wr_mem1", mem[12'hCDE], 32'h88776655);

    mem[12'h010] = 32'hA1B2C3D4;
    ref_mem[12'h010] = 32'hA1B2C3D4;
    plan_q = '{0};
    run_cmd(12'h010, 0, 0, 0, 0);
    plan_q = '{0, 0, 0};
    run_cmd(12'hFFF, 2, 0, 0, 1);
    plan_q = '{0, 0, 0};
    run_cmd(12'hFFF, 2, 0, 1, 1);
    plan_q = '{1, 0};
    run_cmd(12'h123, 1, 0, 1, 1);
    plan_q = '{2};
    run_cmd(12'h200, 0, 0, 0, 1);
    fill(1, 1, 0);
    plan_q = '{2, 0};
    run_cmd(12'hFFE, 1, 1, 1, 1);

    for (int t = 0; t < 24; t++) begin
      int cnt = $urandom_range(0, 3);
      bit wr = 1'($urandom_range(0, 1));
      fill(cnt, wr, 1);
      run_cmd($urandom_range(0, 1) ? AW'($urandom) : AW'(12'hFFD + $urandom_range(0, 2)),
              cnt, wr, 1'($urandom_range(0, 1)), 1);
    end

    // silent slave: watchdog or indefinite wait
    slave_en = 0;
    @(negedge i_clk);
    i_mreq_valid = 1; i_mreq_addr = 12'h055; i_mreq_cnt = 0; i_mreq_wr = 0; i_mreq_aincr = 0;
    @(negedge i_clk);
    i_mreq_valid = 0;
    n = 0;
    while (o_wb_cyc && n < 1100) begin
      n++;
      @(negedge i_clk);
    end
`ifdef WBCON_EXEC_TIMEOUT_EN
    check("timeout_cycles", n, 256);
    check("timeout_err", o_err, 1);
`else
    check("no_timeout", n >= 1000, 1);
`endif
    #2 i_rst_n = 0;
    #1 check("rst_async_cyc", o_wb_cyc, 0);
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    check("rst_recover_ready", o_mreq_ready, 1);

    // reset asserted while a write beat is on the bus
    i_mreq_valid = 1; i_mreq_addr = 12'h3A5; i_mreq_cnt = 0; i_mreq_wr = 1; i_mreq_aincr = 0;
    @(negedge i_clk);
    i_mreq_valid = 0;
    n = 0;
    while (!o_wb_cyc && n < 50) begin
      i_body_valid = 1;
      i_body_data = 8'hA0 + 8'(n);
      @(negedge i_clk);
      n++;
    end
    i_body_valid = 0;
    check("wr_bus_reached", o_wb_cyc, 1);
    check("wr_bus_we", o_wb_we, 1);
    #2 i_rst_n = 0;
    #1;
    check("rst_cyc_mid", o_wb_cyc, 0);
    check("rst_stb_mid", o_wb_stb, 0);
    check("rst_we_mid", o_wb_we, 0);
    check("rst_sel_mid", o_wb_sel, 0);
    check("rst_adr_mid", o_wb_adr, 0);
    check("rst_dat_mid", o_wb_dat, 0);
    check("rst_txd_mid", o_tx_data, 0);
    check("rst_ready_mid", o_mreq_ready, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
    check("rst_mid_ready", o_mreq_ready, 1);
    check("rst_mid_cyc", o_wb_cyc, 0);
    slave_en = 1;
    err_plan.delete();
    fill(1, 0, 0);
    run_cmd(12'h3A5, 1, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
